// File: rtl/key_pulse_gen_if.sv
// Key-panel bundle: raw active-low buttons and enable in, debounced levels and press strobes out.
interface key_pulse_gen_if #(
    parameter int N_KEYS = 6
);
    logic [N_KEYS-1:0] key_n;
    logic              enable;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_pulse;
    logic              any_pulse;

    modport master (
        output key_n,
        output enable,
        input  key_level,
        input  key_pulse,
        input  any_pulse
    );

    modport slave (
        input  key_n,
        input  enable,
        output key_level,
        output key_pulse,
        output any_pulse
    );
endinterface

// File: rtl/key_pulse_gen.sv
// Debounced push-button press strobes, optional hold-to-repeat when KEY_AUTO_REPEAT_EN is defined.
// Latency: key_level/key_pulse rise 2+DEBOUNCE_CYC clocks after a stable press.
// Backpressure: none; strobes are single-cycle and fire-and-forget.
module key_pulse_gen #(
    parameter int N_KEYS            = 6,
    parameter int DEBOUNCE_CYC      = 2_000_000,
    parameter int REPEAT_DELAY_CYC  = 50_000_000,
    parameter int REPEAT_PERIOD_CYC = 10_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    key_pulse_gen_if.slave  bus
);
    localparam int CW = 26;
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYC);

`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY_CYC - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD_CYC - 1);
    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_REPEAT} state_t;
    logic [CW-1:0] hold_cnt [N_KEYS];
`else
    typedef enum logic {ST_IDLE, ST_HELD} state_t;
    // Repeat timing has no meaning when auto-repeat is compiled out.
    wire unused_repeat_cfg = ^{REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC};
`endif

    logic [N_KEYS-1:0] sync1, sync2, pressed;
    logic [N_KEYS-1:0] key_level, key_pulse, rise, fall, pulse_nxt;
    logic              any_pulse;
    logic [CW-1:0]     deb_cnt [N_KEYS];
    state_t            state   [N_KEYS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= bus.key_n;
            sync2 <= sync1;
        end
    end

    assign pressed = ~sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_level <= '0;
            for (int i = 0; i < N_KEYS; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (pressed[i] == key_level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    deb_cnt[i]   <= '0;
                    key_level[i] <= ~key_level[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Level-change events, visible in the same cycle the debouncer commits them.
    always_comb begin
        rise = '0;
        fall = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            rise[i] =  pressed[i] & ~key_level[i] & (deb_cnt[i] == DEB_MAX);
            fall[i] = ~pressed[i] &  key_level[i] & (deb_cnt[i] == DEB_MAX);
        end
    end

    always_comb begin
        pulse_nxt = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (bus.enable && !fall[i]) begin
                case (state[i])
                    ST_IDLE:   pulse_nxt[i] = rise[i];
`ifdef KEY_AUTO_REPEAT_EN
                    ST_HELD:   pulse_nxt[i] = (hold_cnt[i] == DELAY_LAST);
                    ST_REPEAT: pulse_nxt[i] = (hold_cnt[i] == PERIOD_LAST);
`endif
                    default:   pulse_nxt[i] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_pulse <= '0;
            any_pulse <= 1'b0;
            for (int i = 0; i < N_KEYS; i++) begin
                state[i] <= ST_IDLE;
`ifdef KEY_AUTO_REPEAT_EN
                hold_cnt[i] <= '0;
`endif
            end
        end else begin
            key_pulse <= pulse_nxt;
            any_pulse <= |pulse_nxt;
            for (int i = 0; i < N_KEYS; i++) begin
                // A key already down when enable rises stays IDLE until re-pressed.
                if (!bus.enable || fall[i]) begin
                    state[i] <= ST_IDLE;
`ifdef KEY_AUTO_REPEAT_EN
                    hold_cnt[i] <= '0;
`endif
                end else begin
                    case (state[i])
                        ST_IDLE: begin
                            if (rise[i]) begin
                                state[i] <= ST_HELD;
`ifdef KEY_AUTO_REPEAT_EN
                                hold_cnt[i] <= '0;
`endif
                            end
                        end
`ifdef KEY_AUTO_REPEAT_EN
                        ST_HELD, ST_REPEAT: begin
                            if (pulse_nxt[i]) begin
                                state[i]    <= ST_REPEAT;
                                hold_cnt[i] <= '0;
                            end else if (hold_cnt[i] != '1) begin
                                hold_cnt[i] <= hold_cnt[i] + 1'b1;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.key_level = key_level;
    assign bus.key_pulse = key_pulse;
    assign bus.any_pulse = any_pulse;
endmodule

// File: tb/tb_key_pulse_gen.sv
// Randomized and directed bench for key_pulse_gen against a window/age-based reference model.
module tb_key_pulse_gen;
    localparam int NK  = 6;
    localparam int DEB = 4;
    localparam int DLY = 20;
    localparam int PER = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_pulse_gen_if #(.N_KEYS(NK)) bus ();

    key_pulse_gen #(
        .N_KEYS(NK),
        .DEBOUNCE_CYC(DEB),
        .REPEAT_DELAY_CYC(DLY),
        .REPEAT_PERIOD_CYC(PER)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw input history per key, debounced level, armed flag and press age.
    logic [DEB+2:0]  hist [NK];
    logic [NK-1:0]   m_level;
    logic [NK-1:0]   m_pulse;
    bit              armed [NK];
    int              age   [NK];

    int edge_no = 0;
    int watch_k = 0;
    bit watch_on = 0;
    int pq[$];
    int exp_q[$];

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            hist[k]  = '1;
            armed[k] = 0;
            age[k]   = 0;
        end
        m_level = '0;
        m_pulse = '0;
    endtask

    // A level flips when the DEB+1 raw samples seen through the 2-cycle synchronizer all disagree with it.
    task automatic model_edge(input logic [NK-1:0] kn, input logic en);
        for (int k = 0; k < NK; k++) begin
            logic tog;
            logic p;
            hist[k] = {hist[k][DEB+1:0], kn[k]};
            tog = 1'b1;
            for (int j = 2; j <= DEB + 2; j++)
                if (hist[k][j] != m_level[k]) tog = 1'b0;
            p = 1'b0;
            if (tog && !m_level[k]) begin
                armed[k] = en;
                age[k]   = 0;
                p        = en;
            end else if (tog) begin
                armed[k] = 0;
            end else if (armed[k]) begin
                if (!en) armed[k] = 0;
                else begin
                    age[k]++;
`ifdef KEY_AUTO_REPEAT_EN
                    p = (age[k] >= DLY) && (((age[k] - DLY) % PER) == 0);
`endif
                end
            end
            if (tog) m_level[k] = ~m_level[k];
            m_pulse[k] = p;
        end
    endtask

    // Called at a negedge: apply inputs for the next posedge, then check after it.
    task automatic step(input logic [NK-1:0] kn, input logic en);
        bus.key_n  = kn;
        bus.enable = en;
        model_edge(kn, en);
        @(negedge clk);
        check("key_level", bus.key_level, m_level);
        check("key_pulse", bus.key_pulse, m_pulse);
        check("any_pulse", bus.any_pulse, |m_pulse);
        if (watch_on && bus.key_pulse[watch_k]) pq.push_back(edge_no);
        edge_no++;
    endtask

    task automatic do_reset(input logic [NK-1:0] kn);
        bus.key_n = kn;
        #1 rst_n = 1'b0;
        #1;
        check("rst_level", bus.key_level, 0);
        check("rst_pulse", bus.key_pulse, 0);
        check("rst_any",   bus.any_pulse, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        edge_no = 0;
    endtask

    task automatic hold(input logic [NK-1:0] kn, input logic en, input int n);
        for (int i = 0; i < n; i++) step(kn, en);
    endtask

    logic [NK-1:0] kn_r;
    logic          en_r;
    int            run_left [NK];

    initial begin
        bus.key_n  = '1;
        bus.enable = 1'b1;
        model_reset();
        @(negedge clk);
        check("init_level", bus.key_level, 0);
        check("init_pulse", bus.key_pulse, 0);
        check("init_any",   bus.any_pulse, 0);
        rst_n = 1'b1;
        hold('1, 1'b1, 4);

        // Short glitch on key 0.
        hold(6'b111110, 1'b1, 3);
        hold('1, 1'b1, 10);

        // Single press on key 0: level and strobe at relative edge 6.
        hold(6'b111110, 1'b1, 7);
        check("p0_level", bus.key_level[0], 1);
        check("p0_any",   bus.any_pulse, 1);
        step(6'b111110, 1'b1);
        check("p0_pulse_off", bus.key_pulse[0], 0);
        hold('1, 1'b1, 10);

        // Long hold on key 2.
        edge_no = 0; pq.delete(); watch_k = 2; watch_on = 1;
        hold(6'b111011, 1'b1, 60);
        watch_on = 0;
`ifdef KEY_AUTO_REPEAT_EN
        exp_q = {6, 26, 34, 42, 50, 58};
`else
        exp_q = {6};
`endif
        check("rpt_count", pq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check("rpt_edge", (i < pq.size()) ? pq[i] : -1, exp_q[i]);
        hold('1, 1'b1, 10);

        // Key 1 pressed while disabled, then re-pressed after enable.
        hold(6'b111101, 1'b0, 30);
        hold(6'b111101, 1'b1, 10);
        hold('1, 1'b1, 10);
        edge_no = 0; pq.delete(); watch_k = 1; watch_on = 1;
        hold(6'b111101, 1'b1, 12);
        watch_on = 0;
        check("repress_count", pq.size(), 1);
        check("repress_edge", (pq.size() > 0) ? pq[0] : -1, 6);
        hold('1, 1'b1, 10);

        // Keys 3 and 4 together, then reset while repeating.
        hold(6'b100111, 1'b1, 7);
        check("dual_pulse", bus.key_pulse, 6'b011000);
        hold(6'b100111, 1'b1, 30);
        do_reset(6'b100111);
        hold(6'b100111, 1'b1, 7);
        check("post_rst_pulse", bus.key_pulse, 6'b011000);
        hold('1, 1'b1, 10);

        // Random key runs, enable toggling, occasional resets.
        kn_r = '1;
        en_r = 1'b1;
        for (int k = 0; k < NK; k++) run_left[k] = $urandom_range(0, 20);
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (run_left[k] == 0) begin
                    kn_r[k] = ~kn_r[k];
                    run_left[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5)
                                                              : $urandom_range(6, 45);
                end else begin
                    run_left[k]--;
                end
            end
            if (en_r && $urandom_range(0, 299) == 0) en_r = 1'b0;
            else if (!en_r && $urandom_range(0, 39) == 0) en_r = 1'b1;
            if ($urandom_range(0, 999) == 0) do_reset(kn_r);
            step(kn_r, en_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/key_pulse_gen.md
KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 Parameter N_KEYS, default 6: number of independent key channels (ordered freq_up, freq_dn, amp_up, amp_dn, duty_up, thd_adjust).
REQ-002 Parameter DEBOUNCE_CYC, default 2_000_000: stable-sample cycles required to accept a level change (20 ms at 100 MHz); legal range 1..2^26-1.
REQ-003 Parameter REPEAT_DELAY_CYC, default 50_000_000: hold time before the first auto-repeat pulse (500 ms).
REQ-004 Parameter REPEAT_PERIOD_CYC, default 10_000_000: interval between subsequent auto-repeat pulses (100 ms).
REQ-005 clk  input  1  system clock, 100 MHz.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 key_n  input  N_KEYS  raw push-button levels, active-low, asynchronous to clk.
REQ-008 enable  input  1  pulse generation enable; driven by the test-mode flag.
REQ-009 key_level  output  N_KEYS  debounced pressed state, 1 = pressed.
REQ-010 key_pulse  output  N_KEYS  one-clk press strobes feeding the threshold-adjust inputs of the auto-test stage.
REQ-011 any_pulse  output  1  OR of key_pulse, registered in the same cycle as key_pulse.

Function
REQ-012 Each key_n bit shall pass through a two-flop synchronizer before any other logic.
REQ-013 Each channel shall hold a debounce counter that clears whenever the synchronized sample equals key_level and otherwise increments.
REQ-014 key_level shall toggle on the edge at which the counter reaches DEBOUNCE_CYC; the counter shall clear on that same edge.
REQ-015 A glitch shorter than DEBOUNCE_CYC synchronized cycles shall produce no change on key_level or key_pulse.
REQ-016 Press latency: key_level and key_pulse shall rise on the same edge, 2+DEBOUNCE_CYC edges after the first edge that samples a stable low key_n.
REQ-017 key_pulse shall be exactly one cycle wide per accepted press; release shall never generate a pulse.
REQ-018 Each channel shall run a per-key FSM: IDLE (released), HELD (pressed, waiting REPEAT_DELAY_CYC), REPEAT (pressed, pulsing every REPEAT_PERIOD_CYC).
REQ-019 Transitions: IDLE->HELD on key_level rise with pulse; HELD->REPEAT with pulse after REPEAT_DELAY_CYC cycles; REPEAT->REPEAT with pulse every REPEAT_PERIOD_CYC cycles; any state->IDLE on key_level fall.
REQ-020 The hold counter shall be 26 bits wide, shall clear on every state entry and on every emitted pulse, and shall never wrap.
REQ-021 While enable=0, key_pulse and any_pulse shall be 0, every FSM shall be forced to IDLE, and debouncing/key_level shall continue.
REQ-022 A key already pressed when enable rises shall produce no pulse until it is released and pressed again.
REQ-023 Simultaneous accepted presses on several channels shall all pulse in the same cycle; no arbitration.

Reset
REQ-024 On rst_n low, synchronizer flops shall load 1 (released), all counters 0, all FSMs IDLE, and key_level, key_pulse, any_pulse shall be 0.
REQ-025 Reset asserted mid-debounce or mid-repeat shall abort the operation; after release, a held key shall be re-debounced from zero and shall pulse once.

Configuration
REQ-026 Macro KEY_AUTO_REPEAT_EN: when defined, the HELD/REPEAT behaviour of REQ-018..REQ-020 shall be compiled in.
REQ-027 Without KEY_AUTO_REPEAT_EN, the FSM shall collapse to IDLE/HELD, no hold counter shall exist, and exactly one pulse shall occur per press.

Verification (DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_PERIOD_CYC=8, enable=1 unless stated)
REQ-028 key_n[0] low for 3 cycles then high -> key_level and key_pulse remain 0.
REQ-029 key_n[0] low at edge 0 and held -> key_level[0]=1 and key_pulse[0]=1 at edge 6; pulse 0 at edge 7; any_pulse=1 at edge 6 only.
REQ-030 key_n[2] held low 60 cycles with KEY_AUTO_REPEAT_EN -> pulses at edges 6, 26, 34, 42, 50, 58; without the macro -> pulse at edge 6 only.
REQ-031 key_n[1] held low with enable=0 for 30 cycles, then enable=1 -> no pulse; release and re-press -> single pulse 6 edges after the re-press.
REQ-032 key_n[3] and key_n[4] fall on the same edge -> key_pulse=6'b011000 for one cycle; rst_n pulsed low during REPEAT -> outputs 0 at once, fresh pulse 6 edges after rst_n release with key still held.
